// File: rtl/tt_seq_pkg.sv
// rtl/tt_seq_pkg.sv - shared state encoding and sizing helpers for the truth-table sequencer
package tt_seq_pkg;

    // Sweep FSM encoding; kept as plain constants so older tools can consume it.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Number of input vectors (truth-table rows) for an n-input block.
    function automatic int vec_count(input int n_in);
        return 2 ** n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - counts the settle window a driven vector is held before sampling
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is flagged during the last held cycle so the FSM leaves on that edge.
    assign expired_o = enable_i && (count_q == LAST);

    // Count 0..SETTLE-1 while enabled; restart on clear or on expiry.
    always_comb begin
        count_d = count_q;
        if (clear_i || expired_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all input vectors through a combinational block and checks Y
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int                 N_IN     = 4,
    parameter int                 SETTLE   = 1,
    parameter logic [2**N_IN-1:0] EXPECTED = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 first_err_valid
);

    localparam int VEC_CNT = vec_count(N_IN);
    localparam int ERR_W   = N_IN + 1;
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(VEC_CNT - 1);

    logic [1:0]         state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [N_IN-1:0]    dut_in_q, dut_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [VEC_CNT-1:0] captured_q, captured_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [N_IN-1:0]    first_err_idx_q, first_err_idx_d;
    logic               first_err_valid_q, first_err_valid_d;

    logic timer_clear;
    logic timer_en;
    logic settle_expired;
    logic exp_bit;
    logic mismatch;
    logic last_vec;

    // The timer only runs while a vector is being held; any other state parks it at zero.
    assign timer_en    = (state_q == ST_DRIVE);
    assign timer_clear = (state_q != ST_DRIVE);

    tt_settle_timer #(
        .SETTLE(SETTLE)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expired_o(settle_expired)
    );

    // Four-state compare: an X or Z from the block under test is never a match.
    assign exp_bit  = EXPECTED[idx_q];
    assign mismatch = (dut_out !== exp_bit);
    assign last_vec = (idx_q == IDX_LAST);

    // Sweep sequencing and result accumulation.
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        dut_in_d          = dut_in_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        captured_d        = captured_q;
        err_count_d       = err_count_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_valid_d = first_err_valid_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    captured_d        = '0;
                    err_count_d       = '0;
                    first_err_valid_d = 1'b0;
                    idx_d             = '0;
                    dut_in_d          = '0;
                    busy_d            = 1'b1;
                    state_d           = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // Only a clean 1 is recorded as 1; unknown levels are stored as 0.
                captured_d[idx_q] = (dut_out === 1'b1);
                if (mismatch) begin
                    err_count_d = err_count_q + ERR_W'(1);
                    if (!first_err_valid_q) begin
                        first_err_idx_d   = idx_q;
                        first_err_valid_d = 1'b1;
                    end
                end
                if (last_vec) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + N_IN'(1);
                    dut_in_d = idx_q + N_IN'(1);
                    state_d  = ST_DRIVE;
                end
            end
            ST_DONE: begin
                busy_d   = 1'b0;
                dut_in_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            idx_q             <= '0;
            dut_in_q          <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            captured_q        <= '0;
            err_count_q       <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            dut_in_q          <= dut_in_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            captured_q        <= captured_d;
            err_count_q       <= err_count_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign dut_in          = dut_in_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign captured        = captured_q;
    assign err_count       = err_count_q;
    assign first_err_idx   = first_err_idx_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - scoreboard bench for truth_table_sequencer
module tb_truth_table_sequencer;

    typedef struct {
        longint cap;
        int     err;
        int     fei;
        bit     fev;
        int     done_cyc;
    } ent_t;

    // Three 4-input checkers (AND-style tables) plus one 3-input, SETTLE=2 checker.
    localparam logic [2:0][15:0] EXP4 = {16'h0000, 16'h8001, 16'h8000};
    localparam logic [7:0]       EXPC = 8'hE8;
    localparam int LAT4 = 16 * (1 + 1);
    localparam int LATC = 8 * (2 + 1);

    logic clk = 1'b0;
    logic reset;
    logic start4;
    logic startc;

    logic [3:0]  din4  [3];
    logic        dout4 [3];
    logic        busy4 [3];
    logic        done4 [3];
    logic [15:0] cap4  [3];
    logic [4:0]  err4  [3];
    logic [3:0]  fei4  [3];
    logic        fev4  [3];
    logic [15:0] tt4   [3];

    logic [2:0] dinc;
    logic       doutc;
    logic       busyc;
    logic       donec;
    logic [7:0] capc;
    logic [3:0] errc;
    logic [2:0] feic;
    logic       fevc;
    logic [7:0] ttc;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    ent_t q0[$];
    ent_t q1[$];
    ent_t q2[$];
    ent_t qc[$];
    bit   c_active = 1'b0;
    int   c_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational blocks under test: each is just a lookup into its table.
    assign dout4[0] = tt4[0][din4[0]];
    assign dout4[1] = tt4[1][din4[1]];
    assign dout4[2] = tt4[2][din4[2]];
    assign doutc    = ttc[dinc];

    truth_table_sequencer #(.N_IN(4), .SETTLE(1), .EXPECTED(16'h8000)) u_a (
        .clk(clk), .reset(reset), .start(start4), .dut_in(din4[0]), .dut_out(dout4[0]),
        .busy(busy4[0]), .done(done4[0]), .captured(cap4[0]), .err_count(err4[0]),
        .first_err_idx(fei4[0]), .first_err_valid(fev4[0]));

    truth_table_sequencer #(.N_IN(4), .SETTLE(1), .EXPECTED(16'h8001)) u_b (
        .clk(clk), .reset(reset), .start(start4), .dut_in(din4[1]), .dut_out(dout4[1]),
        .busy(busy4[1]), .done(done4[1]), .captured(cap4[1]), .err_count(err4[1]),
        .first_err_idx(fei4[1]), .first_err_valid(fev4[1]));

    truth_table_sequencer #(.N_IN(4), .SETTLE(1), .EXPECTED(16'h0000)) u_d (
        .clk(clk), .reset(reset), .start(start4), .dut_in(din4[2]), .dut_out(dout4[2]),
        .busy(busy4[2]), .done(done4[2]), .captured(cap4[2]), .err_count(err4[2]),
        .first_err_idx(fei4[2]), .first_err_valid(fev4[2]));

    truth_table_sequencer #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE8)) u_c (
        .clk(clk), .reset(reset), .start(startc), .dut_in(dinc), .dut_out(doutc),
        .busy(busyc), .done(donec), .captured(capc), .err_count(errc),
        .first_err_idx(feic), .first_err_valid(fevc));

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    task automatic note_unexpected(input string tag);
        n_vec++;
        n_bad++;
        $display("FAIL %s unexpected done: got done=1 at cycle %0d, want no pulse", tag, cyc);
    endtask

    // Reference: captured is the block's own table; errors are the rows where it differs.
    function automatic ent_t model(input longint tt, input longint ex, input int nvec, input int dcyc);
        ent_t   e;
        longint mm;
        mm = tt ^ ex;
        e.cap = tt;
        e.err = 0;
        e.fev = 1'b0;
        e.fei = 0;
        e.done_cyc = dcyc;
        for (int i = 0; i < nvec; i++) begin
            if (mm[i]) begin
                e.err = e.err + 1;
                if (!e.fev) begin
                    e.fev = 1'b1;
                    e.fei = i;
                end
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] and4_table();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = (i == 15);
        return t;
    endfunction

    function automatic logic [7:0] maj3_table();
        logic [7:0] t;
        int a, b, c;
        for (int i = 0; i < 8; i++) begin
            a = (i >> 2) & 1;
            b = (i >> 1) & 1;
            c = i & 1;
            t[i] = (a + b + c) >= 2;
        end
        return t;
    endfunction

    task automatic cmp_done(input string tag, input ent_t e, input longint cap, input longint err,
                            input longint fei, input longint fev);
        chk({tag, " done_cycle"}, longint'(cyc), longint'(e.done_cyc));
        chk({tag, " captured"}, cap, e.cap);
        chk({tag, " err_count"}, err, longint'(e.err));
        chk({tag, " first_err_valid"}, fev, longint'(e.fev));
        if (e.fev) chk({tag, " first_err_idx"}, fei, longint'(e.fei));
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin : mon_a
        ent_t e;
        if (done4[0]) begin
            if (q0.size() == 0) note_unexpected("a");
            else begin
                e = q0.pop_front();
                cmp_done("a", e, longint'(cap4[0]), longint'(err4[0]), longint'(fei4[0]), longint'(fev4[0]));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ent_t e;
        if (done4[1]) begin
            if (q1.size() == 0) note_unexpected("b");
            else begin
                e = q1.pop_front();
                cmp_done("b", e, longint'(cap4[1]), longint'(err4[1]), longint'(fei4[1]), longint'(fev4[1]));
            end
        end
    end

    always @(negedge clk) begin : mon_d
        ent_t e;
        if (done4[2]) begin
            if (q2.size() == 0) note_unexpected("d");
            else begin
                e = q2.pop_front();
                cmp_done("d", e, longint'(cap4[2]), longint'(err4[2]), longint'(fei4[2]), longint'(fev4[2]));
            end
        end
    end

    // The 3-input checker also has its driven vector and busy traced cycle by cycle.
    always @(negedge clk) begin : mon_c
        ent_t e;
        int   o;
        if (donec) begin
            if (qc.size() == 0) note_unexpected("c");
            else begin
                e = qc.pop_front();
                cmp_done("c", e, longint'(capc), longint'(errc), longint'(feic), longint'(fevc));
            end
        end
        if (c_active && cyc >= c_start) begin
            o = cyc - c_start;
            if (o < LATC) begin
                chk("c dut_in step", longint'(dinc), longint'(o / 3));
                chk("c busy in sweep", longint'(busyc), 1);
            end else if (o == LATC) begin
                chk("c dut_in in done", longint'(dinc), 7);
                chk("c busy in done", longint'(busyc), 1);
            end else begin
                chk("c dut_in after done", longint'(dinc), 0);
                chk("c busy after done", longint'(busyc), 0);
                c_active = 1'b0;
            end
        end
    end

    task automatic push4(input int dcyc);
        q0.push_back(model(longint'(tt4[0]), longint'(EXP4[0]), 16, dcyc));
        q1.push_back(model(longint'(tt4[1]), longint'(EXP4[1]), 16, dcyc));
        q2.push_back(model(longint'(tt4[2]), longint'(EXP4[2]), 16, dcyc));
    endtask

    task automatic issue4(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] t2);
        repeat (3) @(negedge clk);
        tt4[0] = t0;
        tt4[1] = t1;
        tt4[2] = t2;
        push4(cyc + 1 + LAT4);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issuec(input logic [7:0] t);
        repeat (3) @(negedge clk);
        ttc = t;
        qc.push_back(model(longint'(t), longint'(EXPC), 8, cyc + 1 + LATC));
        c_start = cyc + 1;
        c_active = 1'b1;
        startc = 1'b1;
        @(negedge clk);
        startc = 1'b0;
    endtask

    task automatic wait_done4(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done4[0]) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL %s timeout: got no done in %0d cycles, want done", tag, limit);
    endtask

    task automatic wait_donec(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (donec) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL %s timeout: got no done in %0d cycles, want done", tag, limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start4 = 1'b0;
        startc = 1'b0;
        for (int i = 0; i < 3; i++) tt4[i] = 16'h0;
        ttc = 8'h0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            chk("reset busy", longint'(busy4[i]), 0);
            chk("reset done", longint'(done4[i]), 0);
            chk("reset dut_in", longint'(din4[i]), 0);
            chk("reset captured", longint'(cap4[i]), 0);
            chk("reset err_count", longint'(err4[i]), 0);
            chk("reset first_err_idx", longint'(fei4[i]), 0);
            chk("reset first_err_valid", longint'(fev4[i]), 0);
        end
        chk("reset c busy", longint'(busyc), 0);
        chk("reset c captured", longint'(capc), 0);
        chk("reset c err_count", longint'(errc), 0);
        reset = 1'b0;

        // AND block against exact, off-by-one and all-zero tables; start re-pulsed in DRIVE.
        issue4(and4_table(), and4_table(), 16'hFFFF);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(60, "directed4");

        for (int k = 0; k < 3; k++) begin
            issue4(16'($urandom()), 16'($urandom()), 16'($urandom()));
            wait_done4(60, "random4");
        end
        issue4(~EXP4[0], ~EXP4[1], ~EXP4[2]);
        wait_done4(60, "allwrong4");

        // Majority block, with a start re-pulse during the first DRIVE.
        issuec(maj3_table());
        startc = 1'b1;
        @(negedge clk);
        startc = 1'b0;
        wait_donec(60, "directedc");
        for (int k = 0; k < 3; k++) begin
            issuec(8'($urandom()));
            wait_donec(60, "randomc");
        end

        // start held through DONE relaunches on the first IDLE edge.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) tt4[i] = 16'($urandom());
        push4(cyc + 1 + LAT4);
        start4 = 1'b1;
        wait_done4(60, "relaunch first");
        push4(cyc + 2 + LAT4);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("relaunch idle busy", longint'(busy4[i]), 0);
            chk("relaunch idle captured held", longint'(cap4[i]), longint'(tt4[i]));
        end
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("relaunch captured cleared", longint'(cap4[i]), 0);
            chk("relaunch err_count cleared", longint'(err4[i]), 0);
            chk("relaunch first_err_valid cleared", longint'(fev4[i]), 0);
            chk("relaunch busy", longint'(busy4[i]), 1);
        end
        wait_done4(60, "relaunch second");

        // Reset mid-cycle part-way through a sweep: immediate abort, no done pulse.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) tt4[i] = ~EXP4[i];
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset errors accumulated", longint'(err4[2] != 5'd0), 1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("abort busy", longint'(busy4[i]), 0);
            chk("abort dut_in", longint'(din4[i]), 0);
            chk("abort err_count", longint'(err4[i]), 0);
            chk("abort done", longint'(done4[i]), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        issue4(16'($urandom()), 16'($urandom()), 16'($urandom()));
        wait_done4(60, "post-reset4");

        repeat (4) @(negedge clk);
        chk("queue a drained", longint'(q0.size()), 0);
        chk("queue b drained", longint'(q1.size()), 0);
        chk("queue d drained", longint'(q2.size()), 0);
        chk("queue c drained", longint'(qc.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
